// File: rtl/retire_trace_checker_pkg.sv
// cpu_trace_pkg: shared types for the retirement trace checker.
//   ret_kind_t   - retired instruction kind encodings (0 = illegal / end of trace)
//   trace_rec_t  - packed {kind,pc,addr,data} trace record, TRACE_REC_W bits
//   ERR_*        - err_code values reported by the checker
//   state_t      - checker FSM states
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    K_ILLEGAL = 4'd0,
    K_SUB     = 4'd1,
    K_MOVL    = 4'd2,
    K_MOVH    = 4'd3,
    K_LD      = 4'd4,
    K_ST      = 4'd5,
    K_JZ      = 4'd6,
    K_JNZ     = 4'd7,
    K_JS      = 4'd8,
    K_JNS     = 4'd9
  } ret_kind_t;

  localparam int TRACE_REC_W  = 52;
  localparam int REC_DATA_LSB = 0;
  localparam int REC_ADDR_LSB = 16;
  localparam int REC_PC_LSB   = 32;
  localparam int REC_KIND_LSB = 48;

  // kind is kept as raw bits: the golden trace and the core may carry
  // encodings outside ret_kind_t and they must still compare exactly.
  typedef struct packed {
    logic [3:0]  kind;
    logic [15:0] pc;
    logic [15:0] addr;
    logic [15:0] data;
  } trace_rec_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_MISMATCH = 3'd1;
  localparam logic [2:0] ERR_EXTRA    = 3'd2;
  localparam logic [2:0] ERR_SHORT    = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  function automatic trace_rec_t make_rec(input logic [3:0] kind, input logic [15:0] pc,
                                          input logic [15:0] addr, input logic [15:0] data);
    trace_rec_t r;
    r.kind = kind;
    r.pc   = pc;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/retire_trace_checker_if.sv
// retire_trace_checker_if: all non-clock signals of the trace checker.
//   retire stream : start, ret_valid, ret_kind, ret_pc, ret_addr, ret_data, halt
//   golden memory : gold_rd, gold_addr -> gold_rdata (one cycle later)
//   status        : busy, done, pass, err_code, err_index, err_exp, err_got, match_count
// master = core / memory / debug side, slave = checker.
interface retire_trace_checker_if #(parameter int IDX_W = 10);
  import cpu_trace_pkg::*;

  logic                   start;
  logic                   ret_valid;
  logic [3:0]             ret_kind;
  logic [15:0]            ret_pc;
  logic [15:0]            ret_addr;
  logic [15:0]            ret_data;
  logic                   halt;

  logic                   gold_rd;
  logic [IDX_W-1:0]       gold_addr;
  logic [TRACE_REC_W-1:0] gold_rdata;

  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [2:0]             err_code;
  logic [IDX_W-1:0]       err_index;
  logic [TRACE_REC_W-1:0] err_exp;
  logic [TRACE_REC_W-1:0] err_got;
  logic [IDX_W:0]         match_count;

  modport master (
    output start, ret_valid, ret_kind, ret_pc, ret_addr, ret_data, halt, gold_rdata,
    input  gold_rd, gold_addr, busy, done, pass, err_code, err_index, err_exp, err_got,
           match_count
  );

  modport slave (
    input  start, ret_valid, ret_kind, ret_pc, ret_addr, ret_data, halt, gold_rdata,
    output gold_rd, gold_addr, busy, done, pass, err_code, err_index, err_exp, err_got,
           match_count
  );

endinterface

// File: rtl/retire_trace_checker_trace_fifo.sv
// trace_fifo: synchronous FIFO buffering retired events ahead of the checker.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   clr_i      : synchronous flush
//   push_i     : write din_i (dropped when full unless popping the same cycle)
//   pop_i      : drop head (ignored when empty)
//   dout_o     : head entry, valid while !empty_o
//   full_o, empty_o
module trace_fifo #(
  parameter int W     = 52,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wptr_q, rptr_q;
  logic         do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // When full, the slot being popped is the one written, so push+pop is safe.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/retire_trace_checker.sv
// retire_trace_checker: compares every retired instruction against a golden
// trace held in an external synchronous memory and reports the first divergence.
//   clk, rst_n : core clock, async active-low reset
//   bus        : retire stream in, golden memory port, status out (slave side)
// Each golden entry takes FETCH -> LOAD -> CHECK (3 cycles); a FIFO absorbs
// retirement bursts in between.
module retire_trace_checker
  import cpu_trace_pkg::*;
#(
  parameter int IDX_W      = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  retire_trace_checker_if.slave bus
);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  // Set once the last index has matched: there is no further golden entry.
  logic                   idx_top_q, idx_top_d;
  trace_rec_t             gold_q, gold_d;
  logic                   halt_seen_q, halt_seen_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [2:0]             err_code_q, err_code_d;
  logic [IDX_W-1:0]       err_index_q, err_index_d;
  logic [TRACE_REC_W-1:0] err_exp_q, err_exp_d;
  logic [TRACE_REC_W-1:0] err_got_q, err_got_d;
  logic [IDX_W:0]         match_count_q, match_count_d;

  logic                   busy;
  logic                   fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
  trace_rec_t             ret_rec, head;
  logic [TRACE_REC_W-1:0] head_bits;

  logic                   fail;
  logic [2:0]             fail_code;
  logic [TRACE_REC_W-1:0] fail_exp, fail_got;

  assign busy      = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_CHECK);
  assign fifo_push = busy && bus.ret_valid;
  assign ret_rec   = make_rec(bus.ret_kind, bus.ret_pc, bus.ret_addr, bus.ret_data);
  assign head      = trace_rec_t'(head_bits);

  trace_fifo #(
    .W     (TRACE_REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (fifo_clr),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (ret_rec),
    .dout_o  (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      idx_top_q     <= 1'b0;
      gold_q        <= '0;
      halt_seen_q   <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_code_q    <= ERR_NONE;
      err_index_q   <= '0;
      err_exp_q     <= '0;
      err_got_q     <= '0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      idx_top_q     <= idx_top_d;
      gold_q        <= gold_d;
      halt_seen_q   <= halt_seen_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      err_code_q    <= err_code_d;
      err_index_q   <= err_index_d;
      err_exp_q     <= err_exp_d;
      err_got_q     <= err_got_d;
      match_count_q <= match_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    idx_top_d     = idx_top_q;
    gold_d        = gold_q;
    halt_seen_d   = halt_seen_q;
    done_d        = done_q;
    pass_d        = pass_q;
    err_code_d    = err_code_q;
    err_index_d   = err_index_q;
    err_exp_d     = err_exp_q;
    err_got_d     = err_got_q;
    match_count_d = match_count_q;
    fifo_pop      = 1'b0;
    fifo_clr      = 1'b0;
    fail          = 1'b0;
    fail_code     = ERR_NONE;
    fail_exp      = gold_q;
    fail_got      = '0;

    if (busy && bus.halt) halt_seen_d = 1'b1;

    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (bus.start) begin
          fifo_clr      = 1'b1;
          idx_d         = '0;
          idx_top_d     = 1'b0;
          halt_seen_d   = 1'b0;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          err_code_d    = ERR_NONE;
          err_index_d   = '0;
          err_exp_d     = '0;
          err_got_d     = '0;
          match_count_d = '0;
          state_d       = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        gold_d  = trace_rec_t'(bus.gold_rdata);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (gold_q.kind == 4'(K_ILLEGAL) || idx_top_q) begin
            fail      = 1'b1;
            fail_code = ERR_EXTRA;
            fail_got  = head;
          end else if (head != gold_q) begin
            fail      = 1'b1;
            fail_code = ERR_MISMATCH;
            fail_got  = head;
          end else begin
            match_count_d = match_count_q + (IDX_W+1)'(1);
            if (idx_q == '1) idx_top_d = 1'b1;
            else             idx_d     = idx_q + IDX_W'(1);
            state_d = S_FETCH;
          end
        end else if (halt_seen_q) begin
          if (idx_top_q) begin
            fail      = 1'b1;
            fail_code = ERR_EXTRA;
          end else if (gold_q.kind == 4'(K_ILLEGAL)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_SHORT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop never coincides with this, so it cannot race a CHECK decision.
    if (fifo_push && fifo_full && !fifo_pop) begin
      fail      = 1'b1;
      fail_code = ERR_OVERFLOW;
      fail_exp  = '0;
      fail_got  = '0;
    end

    if (fail) begin
      state_d     = S_FAIL;
      done_d      = 1'b1;
      pass_d      = 1'b0;
      err_code_d  = fail_code;
      err_index_d = idx_q;
      err_exp_d   = fail_exp;
      err_got_d   = fail_got;
    end
  end

  assign bus.gold_rd     = (state_q == S_FETCH);
  assign bus.gold_addr   = idx_q;
  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.err_code    = err_code_q;
  assign bus.err_index   = err_index_q;
  assign bus.err_exp     = err_exp_q;
  assign bus.err_got     = err_got_q;
  assign bus.match_count = match_count_q;

endmodule
